// File: rtl/ps_filter_pkg.sv
// Shared definitions for the 3x3 pixel-stream neighbourhood filter.
// Used by ps_line_window and ps_filter3x3_top. Optional build macro in the top:
// PS_FILTER_THRESH_EN.
package ps_filter_pkg;

    // Kernel select, latched with each accepted start-of-frame pixel.
    typedef enum logic [1:0] {
        MODE_PASS  = 2'd0,
        MODE_GAUSS = 2'd1,
        MODE_SHARP = 2'd2,
        MODE_EDGE  = 2'd3
    } mode_e;

    // Gaussian: (4c + 2n + d) >> 4
    localparam int GAUSS_CENTRE_SH = 2;
    localparam int GAUSS_NEIGH_SH  = 1;
    localparam int GAUSS_NORM_SH   = 4;

    // Sharpen: 5c - n, built as (c << 2) + c - n
    localparam int SHARP_CENTRE_SH = 2;

    // Laplacian edge: |n - 4c|
    localparam int EDGE_CENTRE_SH  = 2;

    // Guard bits above the pixel width so that no kernel sum can overflow.
    localparam int ACC_GUARD_W = 4;

    function automatic int acc_width(input int data_w);
        return data_w + ACC_GUARD_W;
    endfunction

endpackage

// File: rtl/ps_line_window.sv
// Builds the 3x3 window from raster pixels: two line buffers (rows r-1, r-2),
// three 3-pixel shift registers, col/row counters, SOF sync, window qualification.
// The shift registers form the stage-1 window register of the filter pipeline.
// Window layout o_win[row][col]: row 0 = oldest line (r-2), row 2 = current line;
// col 0 = newest pixel, col 2 = oldest pixel. The centre is always [1][1].
module ps_line_window
    import ps_filter_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int LINE_W = 640,
    parameter int COL_W  = 10
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [DATA_W-1:0]             i_data,
    input  logic                          i_valid,
    input  logic                          i_sof,
    output logic                          o_sof_acc,
    output logic [2:0][2:0][DATA_W-1:0]   o_win,
    output logic                          o_win_valid,
    output logic                          o_win_sof
);

    localparam int              ADDR_W   = (LINE_W > 1) ? $clog2(LINE_W) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_W - 1);
    localparam logic [COL_W-1:0] ROW_MAX  = '1;
    localparam logic [COL_W-1:0] TWO      = COL_W'(2);

    logic [DATA_W-1:0] lb_near [LINE_W];   // line r-1
    logic [DATA_W-1:0] lb_far  [LINE_W];   // line r-2

    logic              accept;
    logic [COL_W-1:0]  col_eff, row_eff;
    logic [ADDR_W-1:0] lb_addr;
    logic [DATA_W-1:0] rd_near, rd_far;

    logic [COL_W-1:0]  col_d, col_q;
    logic [COL_W-1:0]  row_d, row_q;
    logic              synced_d, synced_q;
    logic              win_valid_d, win_valid_q;
    logic              win_sof_d, win_sof_q;
    logic [2:0][2:0][DATA_W-1:0] win_q;

    // A SOF pixel is position (0,0) of a new frame whatever the counters say.
    always_comb begin
        accept  = i_valid & (synced_q | i_sof);
        col_eff = i_sof ? '0 : col_q;
        row_eff = i_sof ? '0 : row_q;
        lb_addr = col_eff[ADDR_W-1:0];
        rd_near = lb_near[lb_addr];
        rd_far  = lb_far[lb_addr];
    end

    assign o_sof_acc = i_valid & i_sof;

    // Counter advance, sync and window qualification for the accepted pixel.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        col_d       = col_q;
        row_d       = row_q;
        synced_d    = synced_q;
        win_valid_d = 1'b0;
        win_sof_d   = 1'b0;
        if (accept) begin
            synced_d    = 1'b1;
            win_valid_d = (row_eff >= TWO) && (col_eff >= TWO);
            win_sof_d   = win_valid_d && (row_eff == TWO) && (col_eff == TWO);
            if (col_eff == COL_LAST) begin
                col_d = '0;
                row_d = (row_eff == ROW_MAX) ? row_eff : row_eff + COL_W'(1);
            end else begin
                col_d = col_eff + COL_W'(1);
                row_d = row_eff;
            end
        end
    end

    // Counters, sync flag, window shift registers and their valid/SOF tags.
    always_ff @(posedge i_clk or posedge i_rst) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (i_rst) begin
            col_q       <= '0;
            row_q       <= '0;
            synced_q    <= 1'b0;
            win_valid_q <= 1'b0;
            win_sof_q   <= 1'b0;
            win_q       <= '0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            synced_q    <= synced_d;
            win_valid_q <= win_valid_d;
            win_sof_q   <= win_sof_d;
            if (accept) begin
                win_q[0] <= {win_q[0][1:0], rd_far};
                win_q[1] <= {win_q[1][1:0], rd_near};
                win_q[2] <= {win_q[2][1:0], i_data};
            end
        end
    end

    // Line buffers: current pixel moves into r-1, the old r-1 entry into r-2.
    always_ff @(posedge i_clk) begin
        // NOTE: line-buffer RAM has no reset; windows only read it after two fresh lines are written.
        if (accept) begin
            lb_near[lb_addr] <= i_data;
            lb_far[lb_addr]  <= rd_near;
        end
    end

    assign o_win       = win_q;
    assign o_win_valid = win_valid_q;
    assign o_win_sof   = win_sof_q;

endmodule

// File: rtl/ps_filter3x3_top.sv
// 3x3 neighbourhood filter for the pixel stream: passthrough, Gaussian, sharpen
// and Laplacian edge kernels, selected per frame at SOF.
// Pipeline: stage 1 window register (ps_line_window), stage 2 kernel sums,
// stage 3 normalise/clamp into the output registers. Latency is 3 cycles.
// Optional build macro PS_FILTER_THRESH_EN: adds i_thresh and binarises the
// edge output (all-ones if magnitude >= threshold, else 0).
module ps_filter3x3_top
    import ps_filter_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int LINE_W = 640,
    parameter int COL_W  = 10
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [1:0]        i_mode,
    input  logic              i_sof,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_valid,
`ifdef PS_FILTER_THRESH_EN
    input  logic [DATA_W-1:0] i_thresh,
`endif
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_sof,
    output logic              o_sat
);

    localparam int ACC_W = acc_width(DATA_W);
    localparam logic [ACC_W-1:0] PIX_MAX = {{(ACC_W - DATA_W){1'b0}}, {DATA_W{1'b1}}};

    logic                        sof_acc;
    logic [2:0][2:0][DATA_W-1:0] win;
    logic                        win_valid, win_sof;

    ps_line_window #(
        .DATA_W (DATA_W),
        .LINE_W (LINE_W),
        .COL_W  (COL_W)
    ) u_window (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_data      (i_data),
        .i_valid     (i_valid),
        .i_sof       (i_sof),
        .o_sof_acc   (sof_acc),
        .o_win       (win),
        .o_win_valid (win_valid),
        .o_win_sof   (win_sof)
    );

    // ---------------------------------------------------------------------
    // Per-frame settings
    // ---------------------------------------------------------------------
    mode_e mode_q;
`ifdef PS_FILTER_THRESH_EN
    logic [DATA_W-1:0] thresh_q;
`endif

    // Latch kernel (and threshold) only with an accepted SOF pixel.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mode_q   <= MODE_PASS;
`ifdef PS_FILTER_THRESH_EN
            thresh_q <= '0;
`endif
        end else if (sof_acc) begin
            mode_q   <= mode_e'(i_mode);
`ifdef PS_FILTER_THRESH_EN
            thresh_q <= i_thresh;
`endif
        end
    end

    // ---------------------------------------------------------------------
    // Stage 2: kernel sums
    // ---------------------------------------------------------------------
    function automatic logic [ACC_W-1:0] ext(input logic [DATA_W-1:0] p);
        return {{(ACC_W - DATA_W){1'b0}}, p};
    endfunction

    logic [ACC_W-1:0] cen, nsum, dsum, acc_d;

    // Centre, 4-neighbour and diagonal sums, then the selected kernel.
    always_comb begin
        cen   = ext(win[1][1]);
        nsum  = ext(win[0][1]) + ext(win[2][1]) + ext(win[1][0]) + ext(win[1][2]);
        dsum  = ext(win[0][0]) + ext(win[0][2]) + ext(win[2][0]) + ext(win[2][2]);
        acc_d = cen;
        case (mode_q)
            MODE_GAUSS: acc_d = (cen << GAUSS_CENTRE_SH) + (nsum << GAUSS_NEIGH_SH) + dsum;
            MODE_SHARP: acc_d = (cen << SHARP_CENTRE_SH) + cen - nsum;
            MODE_EDGE:  acc_d = nsum - (cen << EDGE_CENTRE_SH);
            default:    acc_d = cen;
        endcase
    end

    logic              s2_valid_q, s2_sof_q;
    logic [ACC_W-1:0]  s2_acc_q;
    logic [DATA_W-1:0] s2_centre_q;
    mode_e             s2_mode_q;

    // Stage-2 register; an accepted SOF drops whatever of the old frame is in flight.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s2_valid_q  <= 1'b0;
            s2_sof_q    <= 1'b0;
            s2_acc_q    <= '0;
            s2_centre_q <= '0;
            s2_mode_q   <= MODE_PASS;
        end else begin
            s2_valid_q <= win_valid & ~sof_acc;
            s2_sof_q   <= win_valid & win_sof & ~sof_acc;
            if (win_valid) begin
                s2_acc_q    <= acc_d;
                s2_centre_q <= win[1][1];
                s2_mode_q   <= mode_q;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Stage 3: normalise / clamp into the output registers
    // ---------------------------------------------------------------------
    logic [ACC_W-1:0]  mag;
    logic [DATA_W-1:0] res;
    logic              clamp;

    // Gauss truncates; sharpen clamps to [0, max]; edge clamps its magnitude to max.
    always_comb begin
        mag   = s2_acc_q[ACC_W-1] ? (-s2_acc_q) : s2_acc_q;
        res   = s2_centre_q;
        clamp = 1'b0;
        case (s2_mode_q)
            MODE_GAUSS: res = s2_acc_q[GAUSS_NORM_SH +: DATA_W];
            MODE_SHARP: begin
                if (s2_acc_q[ACC_W-1]) begin
                    res   = '0;
                    clamp = 1'b1;
                end else if (s2_acc_q > PIX_MAX) begin
                    res   = '1;
                    clamp = 1'b1;
                end else begin
                    res = s2_acc_q[DATA_W-1:0];
                end
            end
            MODE_EDGE: begin
                if (mag > PIX_MAX) begin
                    res   = '1;
                    clamp = 1'b1;
                end else begin
                    res = mag[DATA_W-1:0];
                end
`ifdef PS_FILTER_THRESH_EN
                res = (res >= thresh_q) ? '1 : '0;
`endif
            end
            default: res = s2_centre_q;
        endcase
    end

    logic              o_valid_d, o_valid_q;
    logic              o_sof_d, o_sof_q;
    logic              o_sat_d, o_sat_q;
    logic [DATA_W-1:0] o_data_d, o_data_q;

    // Output next-state; o_sat is sticky until the next accepted SOF.
    always_comb begin
        o_valid_d = s2_valid_q & ~sof_acc;
        o_sof_d   = s2_valid_q & s2_sof_q & ~sof_acc;
        o_data_d  = o_valid_d ? res : o_data_q;
        o_sat_d   = sof_acc ? 1'b0 : (o_sat_q | (s2_valid_q & clamp));
    end

    // Output registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_valid_q <= 1'b0;
            o_sof_q   <= 1'b0;
            o_sat_q   <= 1'b0;
            o_data_q  <= '0;
        end else begin
            o_valid_q <= o_valid_d;
            o_sof_q   <= o_sof_d;
            o_sat_q   <= o_sat_d;
            o_data_q  <= o_data_d;
        end
    end

    assign o_data  = o_data_q;
    assign o_valid = o_valid_q;
    assign o_sof   = o_sof_q;
    assign o_sat   = o_sat_q;

endmodule

// File: tb/tb_ps_filter3x3_top.sv
// Directed bench for ps_filter3x3_top with LINE_W=8. Expected values are
// hand-computed from the kernel definitions. Honours PS_FILTER_THRESH_EN.
module tb_ps_filter3x3_top;

    localparam int DATA_W = 8;
    localparam int LINE_W = 8;
    localparam int COL_W  = 10;

`ifdef PS_FILTER_THRESH_EN
    localparam int EDGE_STEP = 255;   // 200 >= 150
`else
    localparam int EDGE_STEP = 200;
`endif

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic [1:0]        i_mode;
    logic              i_sof;
    logic [DATA_W-1:0] i_data;
    logic              i_valid;
`ifdef PS_FILTER_THRESH_EN
    logic [DATA_W-1:0] i_thresh;
`endif
    logic [DATA_W-1:0] o_data;
    logic              o_valid;
    logic              o_sof;
    logic              o_sat;

    ps_filter3x3_top #(
        .DATA_W (DATA_W),
        .LINE_W (LINE_W),
        .COL_W  (COL_W)
    ) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_mode  (i_mode),
        .i_sof   (i_sof),
        .i_data  (i_data),
        .i_valid (i_valid),
`ifdef PS_FILTER_THRESH_EN
        .i_thresh(i_thresh),
`endif
        .o_data  (o_data),
        .o_valid (o_valid),
        .o_sof   (o_sof),
        .o_sat   (o_sat)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct {
        int data;
        int sof;
        int sat;
        int cyc;
    } out_t;

    out_t outq[$];

    // Record every output away from the active edge.
    always @(negedge i_clk) begin
        if (o_valid === 1'b1)
            outq.push_back('{int'(o_data), int'(o_sof), int'(o_sat), cyc});
    end

    int total = 0;
    int bad   = 0;
    int sent22_cyc = 0;
    logic [DATA_W-1:0] img [0:4][0:LINE_W-1];

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Missing outputs read back as -1, which no real pixel can equal.
    function automatic int od(input int i);
        return (i < outq.size()) ? outq[i].data : -1;
    endfunction
    function automatic int osof(input int i);
        return (i < outq.size()) ? outq[i].sof : -1;
    endfunction
    function automatic int osat(input int i);
        return (i < outq.size()) ? outq[i].sat : -1;
    endfunction

    task automatic px(input logic [DATA_W-1:0] d, input logic s, input logic v);
        @(posedge i_clk);
        #1;
        i_data  = d;
        i_sof   = s;
        i_valid = v;
    endtask

    task automatic idle(input int n);
        repeat (n) px(8'h00, 1'b0, 1'b0);
    endtask

    task automatic fill(input int v);
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < LINE_W; c++)
                img[r][c] = DATA_W'(v);
    endtask

    // Send the first npix pixels of img in raster order, SOF on pixel 0.
    task automatic send_img(input int npix, input logic [1:0] mode, input bit gaps,
                            input int toggle_at, input logic [1:0] toggle_mode);
        i_mode = mode;
        for (int k = 0; k < npix; k++) begin
            if (gaps)
                for (int g = 0; g < 8 && $urandom_range(1, 0) == 1; g++)
                    px(8'hA5, 1'b1, 1'b0);
            if (k == toggle_at) i_mode = toggle_mode;
            px(img[k / LINE_W][k % LINE_W], k == 0, 1'b1);
            if (k == 2 * LINE_W + 2) sent22_cyc = cyc;
        end
        px(8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        int sof_cnt;
        i_rst   = 1'b1;
        i_mode  = 2'd0;
        i_sof   = 1'b0;
        i_data  = '0;
        i_valid = 1'b0;
`ifdef PS_FILTER_THRESH_EN
        i_thresh = 8'd150;
`endif
        // ---- reset state ----
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_o_valid", int'(o_valid), 0);
        chk("rst_o_data",  int'(o_data),  0);
        chk("rst_o_sof",   int'(o_sof),   0);
        chk("rst_o_sat",   int'(o_sat),   0);
        i_rst = 1'b0;

        // ---- pixels without SOF are discarded ----
        for (int k = 0; k < 24; k++) px(DATA_W'(k * 7 + 3), 1'b0, 1'b1);
        idle(6);
        chk("nosof_outputs", outq.size(), 0);

        // ---- gauss, constant 100, 5 lines ----
        outq.delete();
        fill(100);
        send_img(40, 2'd1, 1'b0, -1, 2'd0);
        idle(6);
        chk("gauss_const_count", outq.size(), 18);
        sof_cnt = 0;
        for (int i = 0; i < 18; i++) begin
            chk($sformatf("gauss_const[%0d]", i), od(i), 100);
            if (osof(i) == 1) sof_cnt++;
        end
        chk("gauss_const_sof_first", osof(0), 1);
        chk("gauss_const_sof_count", sof_cnt, 1);
        chk("gauss_latency", (outq.size() > 0) ? outq[0].cyc - sent22_cyc : -1, 3);

        // ---- sharpen, single 255 at (2,3) ----
        outq.delete();
        fill(0);
        img[2][3] = 8'd255;
        send_img(40, 2'd2, 1'b0, -1, 2'd0);
        idle(6);
        chk("sharp_count",       outq.size(), 18);
        chk("sharp_centre",      od(8),   255);
        chk("sharp_centre_sat",  osat(8), 1);
        chk("sharp_up_nb",       od(2),   0);
        chk("sharp_up_nb_sat",   osat(2), 1);
        chk("sharp_diag_sat",    osat(1), 0);
        chk("sharp_left_nb",     od(7),   0);
        chk("sharp_down_nb",     od(14),  0);
        chk("sharp_sat_held",    int'(o_sat), 1);

        // ---- gauss impulse 160: weights 4/2/1 over 16, o_sat cleared at SOF ----
        outq.delete();
        img[2][3] = 8'd160;
        send_img(40, 2'd1, 1'b0, -1, 2'd0);
        idle(6);
        chk("gimp_centre", od(8), 40);
        chk("gimp_nb",     od(7), 20);
        chk("gimp_nb_up",  od(2), 20);
        chk("gimp_diag",   od(1), 10);
        chk("gimp_far",    od(0), 0);
        chk("gimp_sat0",   osat(0), 0);
        chk("gimp_sat17",  osat(17), 0);

        // ---- edge impulse 255: 255 is not a clamp, 1020 clamps ----
        outq.delete();
        img[2][3] = 8'd255;
        send_img(40, 2'd3, 1'b0, -1, 2'd0);
        idle(6);
        chk("eimp_nb",         od(2),   255);
        chk("eimp_nb_sat",     osat(7), 0);
        chk("eimp_centre",     od(8),   255);
        chk("eimp_centre_sat", osat(8), 1);
        chk("eimp_flat",       od(0),   0);

        // ---- edge, vertical step 0|200 ----
        outq.delete();
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < LINE_W; c++)
                img[r][c] = (c >= 4) ? 8'd200 : 8'd0;
        send_img(40, 2'd3, 1'b0, -1, 2'd0);
        idle(6);
        chk("estep_count", outq.size(), 18);
        chk("estep_l0",  od(0),  0);
        chk("estep_e2",  od(2),  EDGE_STEP);
        chk("estep_e3",  od(3),  EDGE_STEP);
        chk("estep_e9",  od(9),  EDGE_STEP);
        chk("estep_r5",  od(5),  0);
        chk("estep_r16", od(16), 0);
        chk("estep_sat", osat(17), 0);

        // ---- mode toggled mid-frame without SOF: passthrough holds ----
        outq.delete();
        fill(100);
        send_img(40, 2'd0, 1'b0, 8, 2'd3);
        idle(6);
        chk("toggle_count", outq.size(), 18);
        chk("toggle_first", od(0),  100);
        chk("toggle_mid",   od(9),  100);
        chk("toggle_last",  od(17), 100);

        // ---- second SOF mid-frame ----
        outq.delete();
        fill(0);
        img[2][3] = 8'd255;
        send_img(2 * LINE_W + 5, 2'd2, 1'b0, -1, 2'd0);
        idle(4);
        chk("sof2_old_count", outq.size(), 3);
        chk("sof2_sat_before", int'(o_sat), 1);
        outq.delete();
        fill(50);
        send_img(3 * LINE_W, 2'd0, 1'b0, -1, 2'd0);
        idle(6);
        chk("sof2_new_count", outq.size(), 6);
        chk("sof2_new_sof",   osof(0), 1);
        chk("sof2_new_sat",   osat(0), 0);
        chk("sof2_new_data",  od(5), 50);
        chk("sof2_latency", (outq.size() > 0) ? outq[0].cyc - sent22_cyc : -1, 3);

        // ---- random i_valid gaps, passthrough of window centres ----
        outq.delete();
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < LINE_W; c++)
                img[r][c] = DATA_W'(r * 16 + c + 1);
        send_img(40, 2'd0, 1'b1, -1, 2'd0);
        idle(6);
        chk("gaps_count", outq.size(), 18);
        for (int i = 0; i < 18; i++)
            chk($sformatf("gaps_centre[%0d]", i), od(i), (i / 6 + 1) * 16 + (i % 6 + 1) + 1);

        // ---- async reset mid-line ----
        fill(77);
        send_img(2 * LINE_W + 6, 2'd0, 1'b0, -1, 2'd0);
        chk("arst_pre_valid", int'(o_valid), 1);
        #2;
        i_rst = 1'b1;
        #1;
        chk("arst_valid_now", int'(o_valid), 0);
        chk("arst_data_now",  int'(o_data),  0);
        @(negedge i_clk);
        i_rst = 1'b0;
        outq.delete();
        for (int k = 0; k < 16; k++) px(DATA_W'(k + 1), 1'b0, 1'b1);
        idle(6);
        chk("arst_nosof_outputs", outq.size(), 0);
        send_img(3 * LINE_W, 2'd0, 1'b0, -1, 2'd0);
        idle(6);
        chk("arst_new_count", outq.size(), 6);
        chk("arst_new_data",  od(0), 77);
        chk("arst_new_sof",   osof(0), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
